// File: rtl/eth_tx_arbiter_if.sv
// Channel-side and GMII-side signal bundle of the N-channel transmit arbiter.
// master = arbiter view, slave = TX engine / MAC side view.
interface eth_tx_arbiter_if #(
   parameter int N_CH = 3,
   parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
   logic [N_CH-1:0]   ch_req;
   logic [N_CH-1:0]   ch_start;
   logic [N_CH-1:0]   ch_done;
   logic [N_CH-1:0]   ch_tx_en;
   logic [8*N_CH-1:0] ch_txd;
   logic              gmii_tx_en;
   logic [7:0]        gmii_txd;
   logic              busy;
   logic [CH_W-1:0]   cur_ch;
   logic [15:0]       frame_cnt;
   logic              timeout_err;

   modport master (
      input  ch_req, ch_done, ch_tx_en, ch_txd,
      output ch_start, gmii_tx_en, gmii_txd, busy, cur_ch, frame_cnt, timeout_err
   );

   modport slave (
      output ch_req, ch_done, ch_tx_en, ch_txd,
      input  ch_start, gmii_tx_en, gmii_txd, busy, cur_ch, frame_cnt, timeout_err
   );
endinterface

// File: rtl/eth_tx_arbiter.sv
// N-channel GMII transmit arbiter: grant, start pulse, byte mux, inter-frame gap.
// Optional ACTIVE-state watchdog is built only when ARB_TIMEOUT_EN is defined.
module eth_tx_arbiter #(
   parameter int N_CH        = 3,
   parameter int ARB_MODE    = 0,
   parameter int IFG_CYCLES  = 12,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic             i_clk,
   input  logic             i_rst,
   eth_tx_arbiter_if.master if_arb
);

   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_ACTIVE,
      S_GAP
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [CH_W-1:0]   r_cur_ch;
   logic [CH_W-1:0]   r_rr_ptr;
   logic [IFG_W-1:0]  r_ifg_cnt;
   logic [15:0]       r_frame_cnt;
   logic              r_gmii_tx_en;
   logic [7:0]        r_gmii_txd;

   logic [CH_W-1:0]   w_search_base;
   logic [CH_W-1:0]   w_idx;
   logic [CH_W-1:0]   w_win_ch;
   logic              w_win_vld;
   logic              w_grant;
   logic              w_done;
   logic              w_timeout;
   logic              w_ifg_last;
   logic [N_CH-1:0]   w_ch_start;

   // Round-robin pointer holds the first index to search, so reset value 0 favours ch0.
   assign w_search_base = (ARB_MODE == 1) ? r_rr_ptr : '0;

   // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
   always_comb begin
      w_win_vld = 1'b0;
      w_win_ch  = '0;
      w_idx     = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         w_idx = CH_W'((int'(w_search_base) + i) % N_CH);
         if (if_arb.ch_req[w_idx]) begin
            w_win_vld = 1'b1;
            w_win_ch  = w_idx;
         end
      end
   end

   assign w_grant    = (r_state == S_IDLE) && w_win_vld;
   assign w_done     = (r_state == S_ACTIVE) && if_arb.ch_done[r_cur_ch];
   assign w_ifg_last = (int'(r_ifg_cnt) == IFG_CYCLES - 1);

`ifdef ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] r_wdog_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || (r_state != S_ACTIVE)) begin
         r_wdog_cnt <= '0;
      end else begin
         r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
   end

   // A real ch_done on the final watchdog cycle still completes the frame normally.
   assign w_timeout = (r_state == S_ACTIVE) && !w_done &&
                      (int'(r_wdog_cnt) == TIMEOUT_CYC - 1);
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_win_vld) w_next_state = S_GRANT;
         S_GRANT:  w_next_state = S_ACTIVE;
         S_ACTIVE: if (w_done || w_timeout) w_next_state = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
         S_GAP:    if (w_ifg_last) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_ch_start = '0;
      if (r_state == S_GRANT) w_ch_start[r_cur_ch] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cur_ch     <= '0;
         r_rr_ptr     <= '0;
         r_ifg_cnt    <= '0;
         r_frame_cnt  <= '0;
         r_gmii_tx_en <= 1'b0;
         r_gmii_txd   <= '0;
      end else begin
         r_state <= w_next_state;

         if (w_grant) begin
            r_cur_ch <= w_win_ch;
            r_rr_ptr <= (w_win_ch == CH_W'(N_CH - 1)) ? '0 : w_win_ch + 1'b1;
         end

         if (w_done) r_frame_cnt <= r_frame_cnt + 16'd1;

         if (r_state == S_GAP) r_ifg_cnt <= r_ifg_cnt + 1'b1;
         else                  r_ifg_cnt <= '0;

         // Only the granted engine's byte lane can reach the output register.
         if ((r_state == S_GRANT) || (r_state == S_ACTIVE)) begin
            r_gmii_tx_en <= if_arb.ch_tx_en[r_cur_ch];
            r_gmii_txd   <= if_arb.ch_txd[8*r_cur_ch +: 8];
         end else begin
            r_gmii_tx_en <= 1'b0;
            r_gmii_txd   <= '0;
         end
      end
   end

   assign if_arb.ch_start    = w_ch_start;
   assign if_arb.gmii_tx_en  = r_gmii_tx_en;
   assign if_arb.gmii_txd    = r_gmii_txd;
   assign if_arb.busy        = (r_state != S_IDLE);
   assign if_arb.cur_ch      = r_cur_ch;
   assign if_arb.frame_cnt   = r_frame_cnt;
   assign if_arb.timeout_err = w_timeout;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: a fixed-priority and a round-robin instance share one stimulus set.
// Outputs are sampled and inputs driven on the falling clock edge.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;

   localparam int N_CH = 3;
   localparam int IFG  = 12;
   localparam int TOUT = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [2:0]  done;
   logic [2:0]  tx_en;
   logic [23:0] txd;

   int total = 0;
   int bad   = 0;

   logic [8:0] exp_q[$];
   int         grant_fp_q[$];
   int         grant_rr_q[$];

   always #5 clk = ~clk;

   eth_tx_arbiter_if #(.N_CH(N_CH)) if_fp ();
   eth_tx_arbiter_if #(.N_CH(N_CH)) if_rr ();

   assign if_fp.ch_req   = req;
   assign if_fp.ch_done  = done;
   assign if_fp.ch_tx_en = tx_en;
   assign if_fp.ch_txd   = txd;
   assign if_rr.ch_req   = req;
   assign if_rr.ch_done  = done;
   assign if_rr.ch_tx_en = tx_en;
   assign if_rr.ch_txd   = txd;

   eth_tx_arbiter #(.N_CH(N_CH), .ARB_MODE(0), .IFG_CYCLES(IFG), .TIMEOUT_CYC(TOUT)) u_fp (
      .i_clk  (clk),
      .i_rst  (rst),
      .if_arb (if_fp.master)
   );

   eth_tx_arbiter #(.N_CH(N_CH), .ARB_MODE(1), .IFG_CYCLES(IFG), .TIMEOUT_CYC(TOUT)) u_rr (
      .i_clk  (clk),
      .i_rst  (rst),
      .if_arb (if_rr.master)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req   = '0;
      done  = '0;
      tx_en = '0;
      txd   = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (if_fp.ch_start != 3'b000) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (!if_fp.busy) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (if_fp.ch_start !== 3'b000) begin bad++; $display("FAIL reset_start got=%b want=000", if_fp.ch_start); end
      total++;
      if (if_fp.gmii_tx_en !== 1'b0 || if_fp.gmii_txd !== 8'h00) begin bad++; $display("FAIL reset_gmii got=%b/%h want=0/00", if_fp.gmii_tx_en, if_fp.gmii_txd); end
      total++;
      if (if_fp.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", if_fp.busy); end
      total++;
      if (if_fp.cur_ch !== 2'd0) begin bad++; $display("FAIL reset_cur_ch got=%0d want=0", if_fp.cur_ch); end
      total++;
      if (if_fp.frame_cnt !== 16'h0000) begin bad++; $display("FAIL reset_frame_cnt got=%h want=0000", if_fp.frame_cnt); end
      total++;
      if (if_fp.timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b want=0", if_fp.timeout_err); end
   endtask

   task automatic test_single();
      logic [8:0] e;
      logic [8:0] got;
      int         ngap;
      int         nstart;
      exp_q.delete();
      req = 3'b010;
      tick();
      total++;
      if (if_fp.ch_start !== 3'b010) begin bad++; $display("FAIL single_start got=%b want=010", if_fp.ch_start); end
      total++;
      if (if_fp.cur_ch !== 2'd1) begin bad++; $display("FAIL single_cur_ch got=%0d want=1", if_fp.cur_ch); end
      req = 3'b000;
      // k=0 is the GRANT cycle, k=1..20 the ACTIVE cycles; done on the 20th.
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) begin
            e   = exp_q.pop_front();
            got = {if_fp.gmii_tx_en, if_fp.gmii_txd};
            total++;
            if (got !== e) begin bad++; $display("FAIL single_data[%0d] got=%h want=%h", k, got, e); end
         end
         if (k == 1) begin
            total++;
            if (if_fp.ch_start !== 3'b000) begin bad++; $display("FAIL single_start_width got=%b want=000", if_fp.ch_start); end
         end
         tx_en = 3'b111;
         txd   = {8'hEE, 8'(k + 1), 8'hDD};
         exp_q.push_back({1'b1, 8'(k + 1)});
         done  = (k == 20) ? 3'b010 : 3'b000;
         tick();
      end
      done   = 3'b000;
      ngap   = 0;
      nstart = 0;
      for (int k = 0; k < 16; k++) begin
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {if_fp.gmii_tx_en, if_fp.gmii_txd};
            total++;
            if (got !== e) begin bad++; $display("FAIL single_gap_data[%0d] got=%h want=%h", k, got, e); end
         end
         if (if_fp.busy) ngap++;
         if (if_fp.ch_start != 3'b000) nstart++;
         tx_en = 3'b111;
         txd   = 24'hEEEEEE;
         exp_q.push_back(9'h000);
         tick();
      end
      total++;
      if (ngap != IFG) begin bad++; $display("FAIL single_gap_len got=%0d want=%0d", ngap, IFG); end
      total++;
      if (nstart != 0) begin bad++; $display("FAIL single_extra_start got=%0d want=0", nstart); end
      total++;
      if (if_fp.frame_cnt !== 16'd1) begin bad++; $display("FAIL single_frame_cnt got=%0d want=1", if_fp.frame_cnt); end
      idle_inputs();
      exp_q.delete();
   endtask

   task automatic test_arbitration();
      int         n;
      int         e;
      logic [2:0] want;
      logic [15:0] fc_fp;
      logic [15:0] fc_rr;
      bit         ok;
      do_reset();
      grant_fp_q = '{0, 0, 0};
      grant_rr_q = '{0, 1, 2};
      fc_fp = if_fp.frame_cnt;
      fc_rr = if_rr.frame_cnt;
      req = 3'b111;
      n   = 0;
      for (int f = 0; f < 3; f++) begin
         while (if_fp.ch_start == 3'b000 && n < 40) begin
            tick();
            n++;
         end
         total++;
         if (n != ((f == 0) ? 1 : IFG + 2)) begin bad++; $display("FAIL arb_grant_latency[%0d] got=%0d want=%0d", f, n, (f == 0) ? 1 : IFG + 2); end
         e    = grant_fp_q.pop_front();
         want = 3'b001 << e;
         total++;
         if (if_fp.ch_start !== want) begin bad++; $display("FAIL arb_fixed[%0d] got=%b want=%b", f, if_fp.ch_start, want); end
         e    = grant_rr_q.pop_front();
         want = 3'b001 << e;
         total++;
         if (if_rr.ch_start !== want) begin bad++; $display("FAIL arb_rr[%0d] got=%b want=%b", f, if_rr.ch_start, want); end
         tick();
         tick();
         done = 3'b111;
         tick();
         done = 3'b000;
         n    = 1;
      end
      req = 3'b000;
      wait_idle(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL arb_idle got=busy want=idle"); end
      total++;
      if (if_fp.frame_cnt !== fc_fp + 16'd3) begin bad++; $display("FAIL arb_fixed_frames got=%0d want=%0d", if_fp.frame_cnt, fc_fp + 16'd3); end
      total++;
      if (if_rr.frame_cnt !== fc_rr + 16'd3) begin bad++; $display("FAIL arb_rr_frames got=%0d want=%0d", if_rr.frame_cnt, fc_rr + 16'd3); end
   endtask

   task automatic test_ignored_done();
      logic [15:0] fc0;
      logic [8:0]  got;
      bit          ok;
      fc0 = if_fp.frame_cnt;
      req = 3'b001;
      wait_start(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL ign_start got=none want=001"); end
      req   = 3'b000;
      tx_en = 3'b111;
      txd   = {8'hEE, 8'hFF, 8'h11};
      done  = 3'b001;
      tick();
      got = {if_fp.gmii_tx_en, if_fp.gmii_txd};
      total++;
      if (got !== 9'h111) begin bad++; $display("FAIL ign_grant_data got=%h want=111", got); end
      total++;
      if (if_fp.frame_cnt !== fc0) begin bad++; $display("FAIL ign_done_in_grant got=%0d want=%0d", if_fp.frame_cnt, fc0); end
      txd  = {8'hEE, 8'hFF, 8'h22};
      done = 3'b100;
      tick();
      got = {if_fp.gmii_tx_en, if_fp.gmii_txd};
      total++;
      if (got !== 9'h122) begin bad++; $display("FAIL ign_active_data got=%h want=122", got); end
      txd  = {8'hEE, 8'hFF, 8'h33};
      done = 3'b000;
      tick();
      got = {if_fp.gmii_tx_en, if_fp.gmii_txd};
      total++;
      if (got !== 9'h133) begin bad++; $display("FAIL ign_still_active got=%h want=133", got); end
      total++;
      if (if_fp.frame_cnt !== fc0) begin bad++; $display("FAIL ign_spurious_done got=%0d want=%0d", if_fp.frame_cnt, fc0); end
      done = 3'b001;
      tick();
      done = 3'b000;
      total++;
      if (if_fp.frame_cnt !== fc0 + 16'd1) begin bad++; $display("FAIL ign_real_done got=%0d want=%0d", if_fp.frame_cnt, fc0 + 16'd1); end
      idle_inputs();
      wait_idle(ok);
   endtask

   task automatic test_gap_requests();
      int n;
      int nstart;
      bit ok;
      req = 3'b001;
      wait_start(ok);
      req = 3'b000;
      tick();
      done = 3'b001;
      req  = 3'b010;
      tick();
      done = 3'b000;
      n    = 1;
      while (if_fp.ch_start == 3'b000 && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (n != IFG + 2) begin bad++; $display("FAIL gap_done_and_req latency got=%0d want=%0d", n, IFG + 2); end
      total++;
      if (if_fp.ch_start !== 3'b010) begin bad++; $display("FAIL gap_next_grant got=%b want=010", if_fp.ch_start); end
      req = 3'b000;
      tick();
      done = 3'b010;
      tick();
      done   = 3'b000;
      nstart = 0;
      for (int k = 0; k < 40; k++) begin
         req = (k < 5) ? 3'b100 : 3'b000;
         if (if_fp.ch_start != 3'b000) nstart++;
         tick();
      end
      total++;
      if (nstart != 0) begin bad++; $display("FAIL gap_dropped_req starts got=%0d want=0", nstart); end
      total++;
      if (if_fp.busy !== 1'b0) begin bad++; $display("FAIL gap_dropped_req busy got=%b want=0", if_fp.busy); end
   endtask

   task automatic test_mid_reset();
      bit ok;
      req = 3'b010;
      wait_start(ok);
      req   = 3'b000;
      tx_en = 3'b111;
      txd   = 24'h555555;
      tick();
      tick();
      total++;
      if (if_fp.cur_ch !== 2'd1 || if_fp.gmii_tx_en !== 1'b1) begin bad++; $display("FAIL rst_pre_state cur_ch=%0d tx_en=%b want=1/1", if_fp.cur_ch, if_fp.gmii_tx_en); end
      rst = 1'b1;
      req = 3'b001;
      tick();
      total++;
      if (if_fp.gmii_tx_en !== 1'b0 || if_fp.busy !== 1'b0) begin bad++; $display("FAIL rst_outputs tx_en=%b busy=%b want=0/0", if_fp.gmii_tx_en, if_fp.busy); end
      total++;
      if (if_fp.frame_cnt !== 16'h0000) begin bad++; $display("FAIL rst_frame_cnt got=%h want=0000", if_fp.frame_cnt); end
      total++;
      if (if_fp.cur_ch !== 2'd0) begin bad++; $display("FAIL rst_cur_ch got=%0d want=0", if_fp.cur_ch); end
      tick();
      total++;
      if (if_fp.ch_start !== 3'b000) begin bad++; $display("FAIL rst_no_start got=%b want=000", if_fp.ch_start); end
      idle_inputs();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      logic [15:0] fc0;
      int          n;
      bit          ok;
      bit          seen_err;
      bit          lost_busy;
      fc0 = if_fp.frame_cnt;
      req = 3'b001;
      wait_start(ok);
      req = 3'b000;
`ifdef ARB_TIMEOUT_EN
      n = 0;
      while (n < 200) begin
         tick();
         n++;
         if (if_fp.timeout_err) break;
      end
      total++;
      if (n != TOUT) begin bad++; $display("FAIL timeout_cycle got=%0d want=%0d", n, TOUT); end
      tick();
      total++;
      if (if_fp.timeout_err !== 1'b0 || if_fp.busy !== 1'b1) begin bad++; $display("FAIL timeout_gap err=%b busy=%b want=0/1", if_fp.timeout_err, if_fp.busy); end
      total++;
      if (if_fp.frame_cnt !== fc0) begin bad++; $display("FAIL timeout_frame_cnt got=%0d want=%0d", if_fp.frame_cnt, fc0); end
      wait_idle(ok);
`else
      seen_err  = 1'b0;
      lost_busy = 1'b0;
      n         = 0;
      for (int k = 0; k < 150; k++) begin
         tick();
         n++;
         if (if_fp.timeout_err) seen_err = 1'b1;
         if (!if_fp.busy) lost_busy = 1'b1;
      end
      total++;
      if (seen_err) begin bad++; $display("FAIL no_watchdog_err got=1 want=0 after %0d cycles", n); end
      total++;
      if (lost_busy) begin bad++; $display("FAIL no_watchdog_busy got=dropped want=held"); end
      done = 3'b001;
      tick();
      done = 3'b000;
      total++;
      if (if_fp.frame_cnt !== fc0 + 16'd1) begin bad++; $display("FAIL no_watchdog_done got=%0d want=%0d", if_fp.frame_cnt, fc0 + 16'd1); end
      wait_idle(ok);
`endif
   endtask

   task automatic test_wrap();
      bit ok;
      force u_fp.r_frame_cnt = 16'hFFFF;
      #1;
      release u_fp.r_frame_cnt;
      tick();
      total++;
      if (if_fp.frame_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h want=ffff", if_fp.frame_cnt); end
      req = 3'b001;
      wait_start(ok);
      req = 3'b000;
      tick();
      done = 3'b001;
      tick();
      done = 3'b000;
      total++;
      if (if_fp.frame_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_frame_cnt got=%h want=0000", if_fp.frame_cnt); end
      wait_idle(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL wrap_idle got=busy want=idle"); end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_arbitration();
      test_ignored_done();
      test_gap_requests();
      test_mid_reset();
      test_timeout();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
